// File: rtl/control_sequencer_pkg.sv
// Shared CPU constants: opcodes, ALU select codes, sequencer states and control-word layout.
// The datapath ALU imports the same ALU_* constants.
package cpu_pkg;

    localparam int unsigned OPCODE_W = 5;
    localparam int unsigned STATE_W  = 5;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_SHR  = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;
    localparam logic [4:0] OP_OR   = 5'd10;
    localparam logic [4:0] OP_ADDI = 5'd11;
    localparam logic [4:0] OP_ANDI = 5'd12;
    localparam logic [4:0] OP_ORI  = 5'd13;
    localparam logic [4:0] OP_MUL  = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_NEG  = 5'd16;
    localparam logic [4:0] OP_NOT  = 5'd17;
    localparam logic [4:0] OP_BR   = 5'd18;
    localparam logic [4:0] OP_JR   = 5'd19;
    localparam logic [4:0] OP_JAL  = 5'd20;
    localparam logic [4:0] OP_IN   = 5'd21;
    localparam logic [4:0] OP_OUT  = 5'd22;
    localparam logic [4:0] OP_MFHI = 5'd23;
    localparam logic [4:0] OP_MFLO = 5'd24;
    localparam logic [4:0] OP_NOP  = 5'd25;
    localparam logic [4:0] OP_HALT = 5'd26;

    localparam logic [3:0] ALU_NONE = 4'h0;
    localparam logic [3:0] ALU_ADD  = 4'h1;
    localparam logic [3:0] ALU_SUB  = 4'h2;
    localparam logic [3:0] ALU_SHR  = 4'h3;
    localparam logic [3:0] ALU_SHL  = 4'h4;
    localparam logic [3:0] ALU_ROR  = 4'h5;
    localparam logic [3:0] ALU_AND  = 4'h6;
    localparam logic [3:0] ALU_OR   = 4'h7;
    localparam logic [3:0] ALU_ROL  = 4'h8;
    localparam logic [3:0] ALU_INC  = 4'h9;
    localparam logic [3:0] ALU_MUL  = 4'hA;
    localparam logic [3:0] ALU_DIV  = 4'hB;
    localparam logic [3:0] ALU_NEG  = 4'hC;
    localparam logic [3:0] ALU_NOT  = 4'hD;

    typedef enum logic [STATE_W-1:0] {
        T0   = 5'd0,
        T1   = 5'd1,
        T2   = 5'd2,
        T3   = 5'd3,
        T4   = 5'd4,
        T5   = 5'd5,
        T6   = 5'd6,
        T7   = 5'd7,
        HALT = 5'd8
    } state_t;

    typedef struct packed {
        logic ld;
        logic ldi;
        logic st;
        logic rtype;
        logic imm;
        logic muldiv;
        logic negnot;
        logic br;
        logic jr;
        logic jal;
        logic inp;
        logic outp;
        logic mfhi;
        logic mflo;
        logic nop;
        logic halt;
    } iclass_t;

    typedef struct packed {
        logic       pcout, pcin, incpc, marin, mdrin, mdrout, read, write;
        logic       rin, rout, gra, grb, grc, baout, r15ctrl;
        logic       yin, zin, zlowout, zhighout, hiin, hiout, loin, loout, cout;
        logic       irin, conin, conout, inportout, outportin;
        logic [3:0] alu;
    } ctrl_t;

    // ALU operation an opcode applies in its compute step; ALU_NONE where it has none.
    function automatic logic [3:0] alu_of(input logic [4:0] op);
        case (op)
            OP_ADD, OP_ADDI: alu_of = ALU_ADD;
            OP_SUB:          alu_of = ALU_SUB;
            OP_SHR:          alu_of = ALU_SHR;
            OP_SHL:          alu_of = ALU_SHL;
            OP_ROR:          alu_of = ALU_ROR;
            OP_ROL:          alu_of = ALU_ROL;
            OP_AND, OP_ANDI: alu_of = ALU_AND;
            OP_OR, OP_ORI:   alu_of = ALU_OR;
            OP_MUL:          alu_of = ALU_MUL;
            OP_DIV:          alu_of = ALU_DIV;
            OP_NEG:          alu_of = ALU_NEG;
            OP_NOT:          alu_of = ALU_NOT;
            default:         alu_of = ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bus between the hardwired sequencer (master) and the datapath (slave).
interface control_sequencer_if;
    logic [31:0] IR;
    logic        stop;
    logic        Run;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write;
    logic        Rin, Rout, Gra, Grb, Grc, BAout, R15ctrl;
    logic        Yin, Zin, ZLowout, ZHighout, HIin, HIout, LOin, LOout, Cout;
    logic        IRin, conIn, conOut, InPortout, outPortin;
    logic [3:0]  ALUselect;

    modport master (
        input  IR, stop,
        output Run,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write,
        output Rin, Rout, Gra, Grb, Grc, BAout, R15ctrl,
        output Yin, Zin, ZLowout, ZHighout, HIin, HIout, LOin, LOout, Cout,
        output IRin, conIn, conOut, InPortout, outPortin,
        output ALUselect
    );

    modport slave (
        output IR, stop,
        input  Run,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write,
        input  Rin, Rout, Gra, Grb, Grc, BAout, R15ctrl,
        input  Yin, Zin, ZLowout, ZHighout, HIin, HIout, LOin, LOout, Cout,
        input  IRin, conIn, conOut, InPortout, outPortin,
        input  ALUselect
    );
endinterface

// File: rtl/control_sequencer_opcode_decoder.sv
// Maps the IR opcode field to a one-hot instruction class and its number of execute steps (T3 onward).
module opcode_decoder
    import cpu_pkg::*;
(
    input  logic [4:0] opcode,
    output iclass_t    cls,
    output logic [2:0] exec_len
);

    always_comb begin
        cls      = '0;
        exec_len = '0;
        case (opcode)
            OP_LD:   begin cls.ld  = 1'b1; exec_len = 3'd5; end
            OP_LDI:  begin cls.ldi = 1'b1; exec_len = 3'd3; end
            OP_ST:   begin cls.st  = 1'b1; exec_len = 3'd5; end
            OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR:
                     begin cls.rtype  = 1'b1; exec_len = 3'd3; end
            OP_ADDI, OP_ANDI, OP_ORI:
                     begin cls.imm    = 1'b1; exec_len = 3'd3; end
            OP_MUL, OP_DIV:
                     begin cls.muldiv = 1'b1; exec_len = 3'd4; end
            OP_NEG, OP_NOT:
                     begin cls.negnot = 1'b1; exec_len = 3'd2; end
            OP_BR:   begin cls.br   = 1'b1; exec_len = 3'd4; end
            OP_JR:   begin cls.jr   = 1'b1; exec_len = 3'd1; end
            OP_JAL:  begin cls.jal  = 1'b1; exec_len = 3'd2; end
            OP_IN:   begin cls.inp  = 1'b1; exec_len = 3'd1; end
            OP_OUT:  begin cls.outp = 1'b1; exec_len = 3'd1; end
            OP_MFHI: begin cls.mfhi = 1'b1; exec_len = 3'd1; end
            OP_MFLO: begin cls.mflo = 1'b1; exec_len = 3'd1; end
            // halt spends one silent T3 before parking in HALT
            OP_HALT: begin cls.halt = 1'b1; exec_len = 3'd1; end
            default: begin cls.nop  = 1'b1; exec_len = 3'd0; end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control sequencer: fetch T0-T2, opcode-specific execute T3-T7, HALT until reset.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned OPW = 5,
    parameter int unsigned SW  = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    control_sequencer_if.master  cs
);

    if (OPW != OPCODE_W || SW != STATE_W) begin : g_bad_width
        $error("control_sequencer: OPW/SW must match cpu_pkg widths");
    end

    state_t     state_q, state_d;
    logic       run_q;
    iclass_t    cls;
    logic [2:0] exec_len;
    logic [4:0] opcode;
    logic [2:0] last_step;
    logic       is_last;
    ctrl_t      c;

    assign opcode = cs.IR[31 -: OPW];

    opcode_decoder u_dec (
        .opcode   (opcode),
        .cls      (cls),
        .exec_len (exec_len)
    );

    // run_q holds off T0 outputs until the first edge after reset is released
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= T0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    assign last_step = 3'd2 + exec_len;
    assign is_last   = (state_q == state_t'({2'b00, last_step}));

    always_comb begin
        state_d = state_q;
        if (!run_q) begin
            state_d = T0;
        end else if (state_q == HALT) begin
            state_d = HALT;
        end else if (is_last) begin
            state_d = (cls.halt || cs.stop) ? HALT : T0;
        end else begin
            state_d = state_t'(state_q + 5'd1);
        end
    end

    always_comb begin
        c = '0;
        if (run_q) begin
            case (state_q)
                T0: begin c.pcout = 1'b1; c.marin = 1'b1; c.incpc = 1'b1; c.zin = 1'b1; c.alu = ALU_INC; end
                T1: begin c.zlowout = 1'b1; c.pcin = 1'b1; c.read = 1'b1; c.mdrin = 1'b1; end
                T2: begin c.mdrout = 1'b1; c.irin = 1'b1; end
                T3: begin
                    if (cls.ld || cls.ldi || cls.st) begin c.grb = 1'b1; c.baout = 1'b1; c.yin = 1'b1; end
                    if (cls.rtype || cls.imm)        begin c.grb = 1'b1; c.rout = 1'b1; c.yin = 1'b1; end
                    if (cls.muldiv)                  begin c.gra = 1'b1; c.rout = 1'b1; c.yin = 1'b1; end
                    if (cls.negnot) begin c.grb = 1'b1; c.rout = 1'b1; c.zin = 1'b1; c.alu = alu_of(opcode); end
                    if (cls.br)   begin c.gra = 1'b1; c.rout = 1'b1; c.conin = 1'b1; end
                    if (cls.jr)   begin c.gra = 1'b1; c.rout = 1'b1; c.pcin = 1'b1; end
                    if (cls.jal)  begin c.pcout = 1'b1; c.r15ctrl = 1'b1; end
                    if (cls.inp)  begin c.inportout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    if (cls.outp) begin c.gra = 1'b1; c.rout = 1'b1; c.outportin = 1'b1; end
                    if (cls.mfhi) begin c.hiout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    if (cls.mflo) begin c.loout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                end
                T4: begin
                    if (cls.ld || cls.ldi || cls.st) begin c.cout = 1'b1; c.zin = 1'b1; c.alu = ALU_ADD; end
                    if (cls.rtype)  begin c.grc = 1'b1; c.rout = 1'b1; c.zin = 1'b1; c.alu = alu_of(opcode); end
                    if (cls.imm)    begin c.cout = 1'b1; c.zin = 1'b1; c.alu = alu_of(opcode); end
                    if (cls.muldiv) begin c.grb = 1'b1; c.rout = 1'b1; c.zin = 1'b1; c.alu = alu_of(opcode); end
                    if (cls.negnot) begin c.zlowout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    if (cls.br)     begin c.pcout = 1'b1; c.yin = 1'b1; end
                    if (cls.jal)    begin c.gra = 1'b1; c.rout = 1'b1; c.pcin = 1'b1; end
                end
                T5: begin
                    if (cls.ld || cls.st) begin c.zlowout = 1'b1; c.marin = 1'b1; end
                    if (cls.ldi || cls.rtype || cls.imm) begin c.zlowout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    if (cls.muldiv) begin c.zlowout = 1'b1; c.loin = 1'b1; end
                    if (cls.br)     begin c.cout = 1'b1; c.zin = 1'b1; c.alu = ALU_ADD; end
                end
                T6: begin
                    if (cls.ld)     begin c.read = 1'b1; c.mdrin = 1'b1; end
                    if (cls.st)     begin c.gra = 1'b1; c.rout = 1'b1; c.mdrin = 1'b1; end
                    if (cls.muldiv) begin c.zhighout = 1'b1; c.hiin = 1'b1; end
                    if (cls.br)     begin c.zlowout = 1'b1; c.conout = 1'b1; end
                end
                T7: begin
                    if (cls.ld) begin c.mdrout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    if (cls.st) begin c.mdrout = 1'b1; c.write = 1'b1; end
                end
                default: c = '0;
            endcase
        end
    end

    assign cs.Run       = run_q && (state_q != HALT);
    assign cs.PCout     = c.pcout;
    assign cs.PCin      = c.pcin;
    assign cs.IncPC     = c.incpc;
    assign cs.MARin     = c.marin;
    assign cs.MDRin     = c.mdrin;
    assign cs.MDRout    = c.mdrout;
    assign cs.Read      = c.read;
    assign cs.Write     = c.write;
    assign cs.Rin       = c.rin;
    assign cs.Rout      = c.rout;
    assign cs.Gra       = c.gra;
    assign cs.Grb       = c.grb;
    assign cs.Grc       = c.grc;
    assign cs.BAout     = c.baout;
    assign cs.R15ctrl   = c.r15ctrl;
    assign cs.Yin       = c.yin;
    assign cs.Zin       = c.zin;
    assign cs.ZLowout   = c.zlowout;
    assign cs.ZHighout  = c.zhighout;
    assign cs.HIin      = c.hiin;
    assign cs.HIout     = c.hiout;
    assign cs.LOin      = c.loin;
    assign cs.LOout     = c.loout;
    assign cs.Cout      = c.cout;
    assign cs.IRin      = c.irin;
    assign cs.conIn     = c.conin;
    assign cs.conOut    = c.conout;
    assign cs.InPortout = c.inportout;
    assign cs.outPortin = c.outportin;
    assign cs.ALUselect = c.alu;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle control words compared against hand-written tables.
module tb_control_sequencer;

    typedef logic [33:0] vec_t;

    localparam logic [29:0] M_RUN     = 30'd1 << 29;
    localparam logic [29:0] M_PCOUT   = 30'd1 << 28;
    localparam logic [29:0] M_PCIN    = 30'd1 << 27;
    localparam logic [29:0] M_INCPC   = 30'd1 << 26;
    localparam logic [29:0] M_MARIN   = 30'd1 << 25;
    localparam logic [29:0] M_MDRIN   = 30'd1 << 24;
    localparam logic [29:0] M_MDROUT  = 30'd1 << 23;
    localparam logic [29:0] M_READ    = 30'd1 << 22;
    localparam logic [29:0] M_WRITE   = 30'd1 << 21;
    localparam logic [29:0] M_RIN     = 30'd1 << 20;
    localparam logic [29:0] M_ROUT    = 30'd1 << 19;
    localparam logic [29:0] M_GRA     = 30'd1 << 18;
    localparam logic [29:0] M_GRB     = 30'd1 << 17;
    localparam logic [29:0] M_GRC     = 30'd1 << 16;
    localparam logic [29:0] M_BAOUT   = 30'd1 << 15;
    localparam logic [29:0] M_R15     = 30'd1 << 14;
    localparam logic [29:0] M_YIN     = 30'd1 << 13;
    localparam logic [29:0] M_ZIN     = 30'd1 << 12;
    localparam logic [29:0] M_ZLOW    = 30'd1 << 11;
    localparam logic [29:0] M_ZHIGH   = 30'd1 << 10;
    localparam logic [29:0] M_HIIN    = 30'd1 << 9;
    localparam logic [29:0] M_HIOUT   = 30'd1 << 8;
    localparam logic [29:0] M_LOIN    = 30'd1 << 7;
    localparam logic [29:0] M_LOOUT   = 30'd1 << 6;
    localparam logic [29:0] M_COUT    = 30'd1 << 5;
    localparam logic [29:0] M_IRIN    = 30'd1 << 4;
    localparam logic [29:0] M_CONIN   = 30'd1 << 3;
    localparam logic [29:0] M_CONOUT  = 30'd1 << 2;
    localparam logic [29:0] M_INPORT  = 30'd1 << 1;
    localparam logic [29:0] M_OUTPORT = 30'd1 << 0;

    localparam vec_t V_F0   = {M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 4'h9};
    localparam vec_t V_F1   = {M_RUN | M_ZLOW | M_PCIN | M_READ | M_MDRIN, 4'h0};
    localparam vec_t V_F2   = {M_RUN | M_MDROUT | M_IRIN, 4'h0};
    localparam vec_t V_ZERO = '0;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    control_sequencer_if cb ();

    control_sequencer #(.OPW(5), .SW(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cs      (cb.master)
    );

    always #5 clk = ~clk;

    function automatic vec_t obs();
        return {cb.Run, cb.PCout, cb.PCin, cb.IncPC, cb.MARin, cb.MDRin, cb.MDRout, cb.Read, cb.Write,
                cb.Rin, cb.Rout, cb.Gra, cb.Grb, cb.Grc, cb.BAout, cb.R15ctrl,
                cb.Yin, cb.Zin, cb.ZLowout, cb.ZHighout, cb.HIin, cb.HIout, cb.LOin, cb.LOout, cb.Cout,
                cb.IRin, cb.conIn, cb.conOut, cb.InPortout, cb.outPortin, cb.ALUselect};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after the edge that enters T0 with Run=1 (cycle 0).
    task automatic start(input logic [31:0] ir);
        reset_n = 1'b0;
        cb.stop = 1'b0;
        cb.IR   = ir;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        cb.IR   = 32'h0900_0000;
        cb.stop = 1'b0;
        reset_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (obs() !== V_ZERO) begin
            n_fail++;
            $display("FAIL reset: got %h expected %h", obs(), V_ZERO);
        end
    endtask

    task automatic test_ldi();
        vec_t exp[$];
        exp = '{V_F0, V_F1, V_F2,
                {M_RUN | M_GRB | M_BAOUT | M_YIN, 4'h0},
                {M_RUN | M_COUT | M_ZIN, 4'h1},
                {M_RUN | M_ZLOW | M_GRA | M_RIN, 4'h0},
                V_F0};
        start(32'h0900_0000);
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL ldi cycle %0d: got %h expected %h", i, obs(), exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_ld();
        vec_t exp[$];
        exp = '{V_F0, V_F1, V_F2,
                {M_RUN | M_GRB | M_BAOUT | M_YIN, 4'h0},
                {M_RUN | M_COUT | M_ZIN, 4'h1},
                {M_RUN | M_ZLOW | M_MARIN, 4'h0},
                {M_RUN | M_READ | M_MDRIN, 4'h0},
                {M_RUN | M_MDROUT | M_GRA | M_RIN, 4'h0},
                V_F0};
        start(32'h0080_0055);
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL ld cycle %0d: got %h expected %h", i, obs(), exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_br();
        vec_t exp[$];
        exp = '{V_F0, V_F1, V_F2,
                {M_RUN | M_GRA | M_ROUT | M_CONIN, 4'h0},
                {M_RUN | M_PCOUT | M_YIN, 4'h0},
                {M_RUN | M_COUT | M_ZIN, 4'h1},
                {M_RUN | M_ZLOW | M_CONOUT, 4'h0},
                V_F0};
        start(32'h9100_0023);
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL br cycle %0d: got %h expected %h", i, obs(), exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_mul();
        vec_t exp[$];
        exp = '{V_F0, V_F1, V_F2,
                {M_RUN | M_GRA | M_ROUT | M_YIN, 4'h0},
                {M_RUN | M_GRB | M_ROUT | M_ZIN, 4'hA},
                {M_RUN | M_ZLOW | M_LOIN, 4'h0},
                {M_RUN | M_ZHIGH | M_HIIN, 4'h0},
                V_F0};
        start(32'h7000_0000);
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL mul cycle %0d: got %h expected %h", i, obs(), exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_nop_undefined();
        vec_t exp[$];
        exp = '{V_F0, V_F1, V_F2, V_F0};
        start(32'hC800_0000);
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL nop cycle %0d: got %h expected %h", i, obs(), exp[i]);
            end
            tick();
        end
        start(32'hF800_0000);
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL undef cycle %0d: got %h expected %h", i, obs(), exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_halt();
        vec_t exp[$];
        exp = '{V_F0, V_F1, V_F2, {M_RUN, 4'h0}};
        start(32'hD000_0000);
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL halt cycle %0d: got %h expected %h", i, obs(), exp[i]);
            end
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (obs() !== V_ZERO) begin
                n_fail++;
                $display("FAIL halted cycle %0d: got %h expected %h", i + 4, obs(), V_ZERO);
            end
            tick();
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (obs() !== V_ZERO) begin
            n_fail++;
            $display("FAIL halt reset: got %h expected %h", obs(), V_ZERO);
        end
        cb.IR = 32'h0900_0000;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (obs() !== V_F0) begin
            n_fail++;
            $display("FAIL halt restart: got %h expected %h", obs(), V_F0);
        end
    endtask

    task automatic test_reset_mid_st();
        start(32'h1080_0000);
        repeat (4) tick();
        n_checks++;
        if (obs() !== {M_RUN | M_COUT | M_ZIN, 4'h1}) begin
            n_fail++;
            $display("FAIL st T4: got %h expected %h", obs(), {M_RUN | M_COUT | M_ZIN, 4'h1});
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (obs() !== V_ZERO) begin
            n_fail++;
            $display("FAIL st abort: got %h expected %h", obs(), V_ZERO);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (obs() !== V_ZERO || cb.Write !== 1'b0) begin
                n_fail++;
                $display("FAIL st held in reset %0d: got %h expected %h", i, obs(), V_ZERO);
            end
        end
    endtask

    task automatic test_stop_add();
        vec_t exp[$];
        exp = '{V_F1, V_F2,
                {M_RUN | M_GRB | M_ROUT | M_YIN, 4'h0},
                {M_RUN | M_GRC | M_ROUT | M_ZIN, 4'h1},
                {M_RUN | M_ZLOW | M_GRA | M_RIN, 4'h0},
                V_ZERO, V_ZERO};
        start(32'h1800_0000);
        tick();
        cb.stop = 1'b1;
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL stop add cycle %0d: got %h expected %h", i + 1, obs(), exp[i]);
            end
            tick();
        end
        cb.stop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cb.IR   = '0;
        cb.stop = 1'b0;
        test_reset();
        test_ldi();
        test_ld();
        test_br();
        test_mul();
        test_nop_undefined();
        test_halt();
        test_reset_mid_st();
        test_stop_add();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
